// File: rtl/snake_if.sv
// Game-control and renderer-query bundle for snake_engine.
// master: game controller / renderer side; slave: the engine.
//   tick, start, dir, query_idx : controller -> engine
//   is_snake, is_head, is_food  : engine -> renderer, registered query answers
//   length, score, won, lost    : engine -> controller, game status
//   busy                        : engine -> controller, a step is in progress
interface snake_if #(
  parameter int unsigned CW = 10,
  parameter int unsigned LW = 6
);
  logic          tick;
  logic          start;
  logic [1:0]    dir;
  logic [CW-1:0] query_idx;
  logic          is_snake;
  logic          is_head;
  logic          is_food;
  logic [LW-1:0] length;
  logic [LW-1:0] score;
  logic          won;
  logic          lost;
  logic          busy;

  modport master (
    output tick, start, dir, query_idx,
    input  is_snake, is_head, is_food, length, score, won, lost, busy
  );

  modport slave (
    input  tick, start, dir, query_idx,
    output is_snake, is_head, is_food, length, score, won, lost, busy
  );
endinterface

// File: rtl/snake_engine.sv
// Grid snake game-state engine: body store, direction control, collision
// detection, food placement, scoring and a 1-cycle cell query port.
// Ports:
//   master_clk : system clock
//   rst        : synchronous active-high reset
//   bus        : snake_if slave (tick/start/dir/query_idx in; query answers,
//                length, score, won, lost, busy out)
module snake_engine #(
  parameter int unsigned GRID_W    = 30,
  parameter int unsigned GRID_H    = 30,
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned INIT_LEN  = 4,
  parameter int unsigned WIN_LEN   = 22,
  parameter int unsigned WRAP      = 0,
  parameter int unsigned FOOD_INIT = 88,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic   master_clk,
  input  logic   rst,
  snake_if.slave bus
);
  localparam int unsigned N  = GRID_W * GRID_H;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] SENT = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_CHECK, S_MOVE, S_FOOD, S_WON, S_LOST
  } state_t;

  state_t        state;
  logic [1:0]    cur_dir;
  logic [CW-1:0] body [MAX_LEN];
  logic [CW-1:0] food;
  logic [LW-1:0] length;
  logic [LW-1:0] score;
  logic          won;
  logic          lost;
  logic          busy;
  logic          is_snake;
  logic          is_head;
  logic          is_food;
  logic [15:0]   lfsr;

  logic [15:0]   lfsr_nxt;
  logic [CW-1:0] head;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [CW-1:0] next_head;
  logic [CW-1:0] cand;
  logic [CW-1:0] restart_food;
  logic          edge_hit;
  logic          eat;
  logic          collide;
  logic          cand_hit;
  logic          query_hit;

  // Initial body: head at INIT_LEN-1 counting down to cell 0, rest empty.
  function automatic logic [CW-1:0] init_cell(int k);
    return (k < int'(INIT_LEN)) ? CW'(INIT_LEN - 1 - k) : SENT;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11 (shift towards bit 0).
  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  assign head = body[0];
  assign row  = head / CW'(GRID_W);
  assign col  = head % CW'(GRID_W);

  // Candidate food cell; on restart fall back to FOOD_INIT if it lands on the
  // initial body, which always occupies cells 0..INIT_LEN-1.
  assign cand         = CW'(lfsr % 16'(N));
  assign restart_food = (cand >= CW'(INIT_LEN)) ? cand : CW'(FOOD_INIT);

  // Next head cell; wrapping uses row/col tests so nothing crosses zero.
  always_comb begin
    next_head = head;
    edge_hit  = 1'b0;
    case (cur_dir)
      2'd0: begin
        if (col == '0) begin
          if (WRAP != 0) next_head = head + CW'(GRID_W - 1);
          else           edge_hit  = 1'b1;
        end else         next_head = head - CW'(1);
      end
      2'd1: begin
        if (col == CW'(GRID_W - 1)) begin
          if (WRAP != 0) next_head = head - CW'(GRID_W - 1);
          else           edge_hit  = 1'b1;
        end else         next_head = head + CW'(1);
      end
      2'd2: begin
        if (row == '0) begin
          if (WRAP != 0) next_head = head + CW'((GRID_H - 1) * GRID_W);
          else           edge_hit  = 1'b1;
        end else         next_head = head - CW'(GRID_W);
      end
      default: begin
        if (row == CW'(GRID_H - 1)) begin
          if (WRAP != 0) next_head = col;
          else           edge_hit  = 1'b1;
        end else         next_head = head + CW'(GRID_W);
      end
    endcase
  end

  // Parallel compares against every body slot. The tail slot only counts
  // for self-collision when eating, since otherwise it is vacated this step.
  always_comb begin
    eat       = (next_head == food);
    collide   = 1'b0;
    cand_hit  = 1'b0;
    query_hit = 1'b0;
    for (int k = 0; k < int'(MAX_LEN); k++) begin
      if (body[k] == next_head &&
          ((k + 1 < int'(length)) || (eat && k < int'(length))))
        collide = 1'b1;
      if (body[k] == cand) cand_hit = 1'b1;
      if (body[k] != SENT && body[k] == bus.query_idx) query_hit = 1'b1;
    end
  end

  // Game FSM, LFSR and registered query answers.
  always_ff @(posedge master_clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cur_dir  <= 2'd1;
      for (int k = 0; k < int'(MAX_LEN); k++) body[k] <= init_cell(k);
      food     <= CW'(FOOD_INIT);
      length   <= LW'(INIT_LEN);
      score    <= '0;
      won      <= 1'b0;
      lost     <= 1'b0;
      busy     <= 1'b0;
      lfsr     <= LFSR_SEED;
      is_snake <= 1'b0;
      is_head  <= 1'b0;
      is_food  <= 1'b0;
    end else begin
      lfsr     <= lfsr_nxt;
      is_snake <= query_hit;
      is_head  <= (head == bus.query_idx);
      is_food  <= (food == bus.query_idx);
      case (state)
        S_IDLE: if (bus.start) state <= S_RUN;
        S_RUN: begin
          if (bus.tick) begin
            // Reversal pairs differ only in bit 0.
            if (bus.dir != (cur_dir ^ 2'd1)) cur_dir <= bus.dir;
            state <= S_CHECK;
            busy  <= 1'b1;
          end
        end
        S_CHECK: begin
          if (edge_hit || collide) begin
            lost  <= 1'b1;
            busy  <= 1'b0;
            state <= S_LOST;
          end else begin
            state <= S_MOVE;
          end
        end
        S_MOVE: begin
          for (int k = 1; k < int'(MAX_LEN); k++) body[k] <= body[k-1];
          body[0] <= next_head;
          if (!eat) begin
            for (int k = 1; k < int'(MAX_LEN); k++)
              if (k == int'(length)) body[k] <= SENT;
            busy  <= 1'b0;
            state <= S_RUN;
          end else begin
            length <= length + LW'(1);
            score  <= score + LW'(1);
            if (length + LW'(1) == LW'(WIN_LEN)) begin
              won   <= 1'b1;
              busy  <= 1'b0;
              state <= S_WON;
            end else begin
              state <= S_FOOD;
            end
          end
        end
        S_FOOD: begin
          if (!cand_hit) begin
            food  <= cand;
            busy  <= 1'b0;
            state <= S_RUN;
          end
        end
        default: begin
          // WON / LOST: frozen until start reloads the game.
          if (bus.start) begin
            cur_dir <= 2'd1;
            for (int k = 0; k < int'(MAX_LEN); k++) body[k] <= init_cell(k);
            food    <= restart_food;
            length  <= LW'(INIT_LEN);
            score   <= '0;
            won     <= 1'b0;
            lost    <= 1'b0;
            state   <= S_RUN;
          end
        end
      endcase
    end
  end

  assign bus.is_snake = is_snake;
  assign bus.is_head  = is_head;
  assign bus.is_food  = is_food;
  assign bus.length   = length;
  assign bus.score    = score;
  assign bus.won      = won;
  assign bus.lost     = lost;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: three engines (wall / wrap+early food /
// quick win) share one stimulus stream and are checked against a game-level model.
module tb_snake_engine;
  localparam int GW   = 30;
  localparam int GH   = 30;
  localparam int NC   = GW * GH;
  localparam int MAXL = 32;
  localparam int ILEN = 4;
  localparam int NI   = 3;
  localparam int CW   = $clog2(NC + 1);
  localparam int LW   = $clog2(MAXL + 1);
  localparam int SENTV = (1 << CW) - 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          master_clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          start;
  logic [1:0]    dir;
  logic [CW-1:0] query_idx;

  always #5 master_clk = ~master_clk;

  snake_if #(.CW(CW), .LW(LW)) bus_a ();
  snake_if #(.CW(CW), .LW(LW)) bus_b ();
  snake_if #(.CW(CW), .LW(LW)) bus_c ();

  assign bus_a.tick = tick;  assign bus_a.start = start;
  assign bus_a.dir  = dir;   assign bus_a.query_idx = query_idx;
  assign bus_b.tick = tick;  assign bus_b.start = start;
  assign bus_b.dir  = dir;   assign bus_b.query_idx = query_idx;
  assign bus_c.tick = tick;  assign bus_c.start = start;
  assign bus_c.dir  = dir;   assign bus_c.query_idx = query_idx;

  snake_engine #(.WRAP(0), .FOOD_INIT(88), .WIN_LEN(22)) dut_a (
    .master_clk(master_clk), .rst(rst), .bus(bus_a));
  snake_engine #(.WRAP(1), .FOOD_INIT(4), .WIN_LEN(22)) dut_b (
    .master_clk(master_clk), .rst(rst), .bus(bus_b));
  snake_engine #(.WRAP(0), .FOOD_INIT(4), .WIN_LEN(5)) dut_c (
    .master_clk(master_clk), .rst(rst), .bus(bus_c));

  logic [NI-1:0] o_snake, o_head, o_food, o_won, o_lost, o_busy;
  logic [LW-1:0] o_len [NI];
  logic [LW-1:0] o_score [NI];
  assign o_snake = {bus_c.is_snake, bus_b.is_snake, bus_a.is_snake};
  assign o_head  = {bus_c.is_head,  bus_b.is_head,  bus_a.is_head};
  assign o_food  = {bus_c.is_food,  bus_b.is_food,  bus_a.is_food};
  assign o_won   = {bus_c.won,      bus_b.won,      bus_a.won};
  assign o_lost  = {bus_c.lost,     bus_b.lost,     bus_a.lost};
  assign o_busy  = {bus_c.busy,     bus_b.busy,     bus_a.busy};
  assign o_len[0] = bus_a.length;  assign o_score[0] = bus_a.score;
  assign o_len[1] = bus_b.length;  assign o_score[1] = bus_b.score;
  assign o_len[2] = bus_c.length;  assign o_score[2] = bus_c.score;

  // Game-level reference model, one lane per engine.
  int p_wrap [NI] = '{0, 1, 0};
  int p_finit[NI] = '{88, 4, 4};
  int p_win  [NI] = '{22, 22, 5};
  int m_body [NI][MAXL+1];
  int m_len  [NI];
  int m_score[NI];
  int m_dir  [NI];
  int m_food [NI];
  int m_st   [NI];   // 0 idle, 1 running, 2 frozen (won or lost)
  int m_won  [NI];
  int m_lost [NI];
  int m_busy [NI];   // expected number of cycles busy stays high
  int tails  [NI];
  logic [15:0] m_lfsr;
  logic [NI-1:0] r_snake, r_head, r_food;

  int n_chk = 0;
  int n_bad = 0;

  function automatic logic [15:0] lfsr_step(logic [15:0] v);
    int x, b;
    x = int'(v);
    b = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
    return 16'((x >> 1) | (b << 15));
  endfunction

  function automatic logic [15:0] lfsr_ahead(logic [15:0] v, int n);
    logic [15:0] t;
    t = v;
    for (int s = 0; s < n; s++) t = lfsr_step(t);
    return t;
  endfunction

  always @(posedge master_clk) m_lfsr <= rst ? SEED : lfsr_step(m_lfsr);

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit on_body(int i, int c, int upto);
    for (int k = 0; k < upto; k++) if (m_body[i][k] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_load(int i, int fd);
    for (int k = 0; k <= MAXL; k++) m_body[i][k] = (k < ILEN) ? ILEN - 1 - k : -1;
    m_len[i] = ILEN; m_score[i] = 0; m_dir[i] = 1; m_food[i] = fd;
    m_won[i] = 0; m_lost[i] = 0; m_busy[i] = 0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < NI; i++) begin
      m_load(i, p_finit[i]);
      m_st[i] = 0;
    end
  endtask

  task automatic m_start(int i, logic [15:0] l);
    int c;
    if (m_st[i] == 0) m_st[i] = 1;
    else if (m_st[i] == 2) begin
      c = int'(l) % NC;
      m_load(i, (c >= ILEN) ? c : p_finit[i]);
      m_st[i] = 1;
    end
  endtask

  task automatic m_tick(int i, int d, logic [15:0] l);
    int r, c, nh, upto, j;
    bit eat;
    if (d != (m_dir[i] ^ 1)) m_dir[i] = d;
    r = m_body[i][0] / GW;
    c = m_body[i][0] % GW;
    case (m_dir[i])
      0: c = c - 1;
      1: c = c + 1;
      2: r = r - 1;
      default: r = r + 1;
    endcase
    if (c < 0 || c >= GW || r < 0 || r >= GH) begin
      if (p_wrap[i] == 0) begin
        m_lost[i] = 1; m_st[i] = 2; m_busy[i] = 1;
        return;
      end
      c = (c + GW) % GW;
      r = (r + GH) % GH;
    end
    nh   = r * GW + c;
    eat  = (nh == m_food[i]);
    upto = eat ? m_len[i] : m_len[i] - 1;
    if (on_body(i, nh, upto)) begin
      m_lost[i] = 1; m_st[i] = 2; m_busy[i] = 1;
      return;
    end
    for (int k = m_len[i]; k > 0; k--) m_body[i][k] = m_body[i][k-1];
    m_body[i][0] = nh;
    m_busy[i] = 2;
    if (eat) begin
      m_len[i]++;
      m_score[i]++;
      if (m_len[i] == p_win[i]) begin
        m_won[i] = 1; m_st[i] = 2;
      end else begin
        j = 0;
        while (j < 5000 && on_body(i, int'(lfsr_ahead(l, 3 + j)) % NC, m_len[i])) j++;
        m_food[i] = int'(lfsr_ahead(l, 3 + j)) % NC;
        m_busy[i] = 3 + j;
      end
    end
  endtask

  // Query one cell on all engines and compare against the model.
  task automatic query(int q);
    @(negedge master_clk);
    query_idx = CW'(q);
    @(negedge master_clk);
    @(negedge master_clk);
    r_snake = o_snake; r_head = o_head; r_food = o_food;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("q%0d_snake_%0d", q, i), int'(o_snake[i]), int'(on_body(i, q, m_len[i])));
      chk($sformatf("q%0d_head_%0d", q, i), int'(o_head[i]), int'(m_body[i][0] == q));
      chk($sformatf("q%0d_food_%0d", q, i), int'(o_food[i]), int'(m_food[i] == q));
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("len_%0d", i), int'(o_len[i]), m_len[i]);
      chk($sformatf("score_%0d", i), int'(o_score[i]), m_score[i]);
      chk($sformatf("won_%0d", i), int'(o_won[i]), m_won[i]);
      chk($sformatf("lost_%0d", i), int'(o_lost[i]), m_lost[i]);
    end
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < m_len[i]; k++) query(m_body[i][k]);
      query(m_food[i]);
      if (tails[i] >= 0) query(tails[i]);
    end
    query($urandom_range(0, SENTV));
  endtask

  // One input pulse, model update, busy-duration check, then full state check.
  task automatic step(bit t, bit s, int d);
    logic [15:0] l;
    int cnt[NI];
    for (int i = 0; i < NI; i++) tails[i] = m_body[i][m_len[i]-1];
    @(negedge master_clk);
    l = m_lfsr;
    tick = t; start = s; dir = 2'(d);
    for (int i = 0; i < NI; i++) begin
      m_busy[i] = 0;
      cnt[i] = 0;
      if (m_st[i] == 1) begin
        if (t) m_tick(i, d, l);
      end else if (s) begin
        m_start(i, l);
      end
    end
    @(negedge master_clk);
    tick = 1'b0; start = 1'b0;
    for (int c = 0; c < 64; c++) begin
      for (int i = 0; i < NI; i++) if (o_busy[i]) cnt[i]++;
      if (o_busy == '0) break;
      @(negedge master_clk);
    end
    for (int i = 0; i < NI; i++) chk($sformatf("busy_cycles_%0d", i), cnt[i], m_busy[i]);
    check_state();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int r, d;
    rst = 1'b1; tick = 1'b0; start = 1'b0; dir = 2'd0; query_idx = '0;
    for (int i = 0; i < NI; i++) tails[i] = -1;
    m_reset();
    repeat (3) @(negedge master_clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_busy_%0d", i), int'(o_busy[i]), 0);
      chk($sformatf("rst_qsnake_%0d", i), int'(o_snake[i]), 0);
    end
    rst = 1'b0;

    // Reset body / food layout.
    check_state();
    query(3);  chk("rst_head3", int'(r_head[0]), 1);
    query(2);  chk("rst_snake2", int'(r_snake[0]), 1); chk("rst_head2", int'(r_head[0]), 0);
    query(0);  chk("rst_snake0", int'(r_snake[0]), 1);
    query(4);  chk("rst_snake4", int'(r_snake[0]), 0);
    query(88); chk("rst_food88", int'(r_food[0]), 1);
    chk("rst_len", int'(o_len[0]), 4);
    chk("rst_score", int'(o_score[0]), 0);

    // Start, step right: A moves, B eats and places food, C eats and wins.
    step(1'b0, 1'b1, 1);
    step(1'b1, 1'b0, 1);
    query(4); chk("mv_head4", int'(r_head[0]), 1);
    query(0); chk("mv_tail0_a", int'(r_snake[0]), 0); chk("eat_tail0_b", int'(r_snake[1]), 1);
    chk("eat_len_b", int'(o_len[1]), 5);
    chk("eat_score_b", int'(o_score[1]), 1);
    chk("win_c", int'(o_won[2]), 1);

    // Reverse request is ignored.
    step(1'b1, 1'b0, 0);
    query(5); chk("rev_head5", int'(r_head[0]), 1);

    // Tight loop: A steps into its vacating tail, B (length 5) hits itself.
    step(1'b1, 1'b0, 3);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 2);
    chk("tail_move_lost_a", int'(o_lost[0]), 0);
    query(4); chk("tail_move_head_a", int'(r_head[0]), 1);

    // Reset in the middle of B's food search.
    rst = 1'b1;
    @(negedge master_clk);
    rst = 1'b0;
    m_reset();
    step(1'b0, 1'b1, 1);
    @(negedge master_clk); tick = 1'b1; dir = 2'd1;
    @(negedge master_clk); tick = 1'b0;
    @(negedge master_clk);
    @(negedge master_clk);
    chk("food_busy_b", int'(o_busy[1]), 1);
    rst = 1'b1;
    @(negedge master_clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("mid_rst_len_%0d", i), int'(o_len[i]), ILEN);
      chk($sformatf("mid_rst_score_%0d", i), int'(o_score[i]), 0);
      chk($sformatf("mid_rst_won_%0d", i), int'(o_won[i]), 0);
      chk($sformatf("mid_rst_busy_%0d", i), int'(o_busy[i]), 0);
      chk($sformatf("mid_rst_head_%0d", i), int'(o_head[i]), 0);
    end
    rst = 1'b0;
    m_reset();
    check_state();

    // Tick with start in IDLE is dropped; then up from the top row.
    step(1'b1, 1'b1, 2);
    step(1'b1, 1'b0, 2);
    chk("wall_lost_a", int'(o_lost[0]), 1);
    chk("wrap_lost_b", int'(o_lost[1]), 0);
    query(873); chk("wrap_head873_b", int'(r_head[1]), 1);
    step(1'b1, 1'b0, 3);
    query(3); chk("frozen_head3_a", int'(r_head[0]), 1);

    // Randomised play.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      d = $urandom_range(0, 3);
      if (r < 84)      step(1'b1, 1'b0, d);
      else if (r < 95) step(1'b0, 1'b1, d);
      else             step(1'b1, 1'b1, d);
      repeat ($urandom_range(0, 2)) @(negedge master_clk);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
